// File: rtl/serial_match_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_match_ctrl_pkg
// Shared types for the serial "1101" match controller.
//   ctrl_state_e : controller FSM states (IDLE, SHIFT, DRAIN, REPORT)
//   det_state_e  : detector FSM states (IDLE, S1..S4)
//   det_next()   : next-state function of the overlapping Moore "1101"
//                  recognizer; unused encodings fall back to DET_IDLE
// ----------------------------------------------------------------------------
package serial_match_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } ctrl_state_e;

    // S1="1", S2="11", S3="110", S4="1101" seen as the most recent bits
    typedef enum logic [2:0] {
        DET_IDLE = 3'd0,
        DET_S1   = 3'd1,
        DET_S2   = 3'd2,
        DET_S3   = 3'd3,
        DET_S4   = 3'd4
    } det_state_e;

    function automatic det_state_e det_next(input det_state_e cur, input logic bit_in);
        det_state_e nxt;
        case (cur)
            DET_IDLE: nxt = bit_in ? DET_S1 : DET_IDLE;
            DET_S1:   nxt = bit_in ? DET_S2 : DET_IDLE;
            DET_S2:   nxt = bit_in ? DET_S2 : DET_S3;
            DET_S3:   nxt = bit_in ? DET_S4 : DET_IDLE;
            // after "1101" a further 1 leaves "11" as the live prefix
            DET_S4:   nxt = bit_in ? DET_S2 : DET_IDLE;
            default:  nxt = DET_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_det_1101.sv
// ----------------------------------------------------------------------------
// seq_det_1101
// Overlapping Moore recognizer for the bit sequence "1101".
//   clk : system clock
//   rst : asynchronous active-high reset, returns to DET_IDLE
//   clr : synchronous clear to DET_IDLE (wins over en)
//   en  : advance on i this cycle; otherwise the state (history) is held
//   i   : serial input bit
//   o   : 1 while the recognizer sits in S4 (registered)
// ----------------------------------------------------------------------------
module seq_det_1101
    import serial_match_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic i,
    output logic o
);

    det_state_e state;
    det_state_e state_nxt;

    // Next detector state: clear, advance or hold
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = DET_IDLE;
        end else if (en) begin
            state_nxt = det_next(state, i);
        end else begin
            state_nxt = state;
        end
    end

    // Detector state and registered Moore output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DET_IDLE;
            o     <= 1'b0;
        end else begin
            state <= state_nxt;
            o     <= (state_nxt == DET_S4);
        end
    end

endmodule

// File: rtl/serial_match_ctrl.sv
// ----------------------------------------------------------------------------
// serial_match_ctrl
// Accepts one DATA_WIDTH word, shifts it MSB-first through a "1101"
// recognizer and reports how many matches ended inside the word.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : word offered on in_data (taken only while in_ready)
//   in_data   : word to scan
//   keep_hist : 1 = detector history carries over from the previous word
//   in_ready  : controller idle and able to accept a word
//   out_valid : out_count valid (REPORT state)
//   out_count : saturating number of matches in the word
//   out_ready : consumer takes the result
//   busy      : controller not idle
// ----------------------------------------------------------------------------
module serial_match_ctrl
    import serial_match_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  keep_hist,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  out_count,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0]        BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    ctrl_state_e           state;
    ctrl_state_e           state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  accept;
    logic                  det_clr;
    logic                  det_en;
    logic                  det_i;
    logic                  det_o;
    logic                  count_hit;

    assign accept  = in_valid && in_ready;
    assign det_clr = accept && !keep_hist;
    assign det_en  = (state == ST_SHIFT);
    assign det_i   = shreg[DATA_WIDTH-1];

    // With bit_cnt==0 the detector output still reflects the previous
    // word's history, so only matches completed by this word are counted.
    assign count_hit = det_o &&
                       (((state == ST_SHIFT) && (bit_cnt != {BW{1'b0}})) ||
                        (state == ST_DRAIN));

    seq_det_1101 u_det (
        .clk (clk),
        .rst (rst),
        .clr (det_clr),
        .en  (det_en),
        .i   (det_i),
        .o   (det_o)
    );

    // Controller next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_DRAIN: state_nxt = ST_REPORT;
            ST_REPORT: begin
                if (out_valid && out_ready) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_REPORT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Controller state and outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_REPORT);
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    // Shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= {DATA_WIDTH{1'b0}};
            bit_cnt <= {BW{1'b0}};
        end else if (accept) begin
            shreg   <= in_data;
            bit_cnt <= {BW{1'b0}};
        end else if (state == ST_SHIFT) begin
            shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
        end else begin
            shreg   <= shreg;
            bit_cnt <= bit_cnt;
        end
    end

    // Saturating match counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= {CNT_WIDTH{1'b0}};
        end else if (accept) begin
            out_count <= {CNT_WIDTH{1'b0}};
        end else if (count_hit && (out_count != CNT_MAX)) begin
            out_count <= out_count + CNT_WIDTH'(1);
        end else begin
            out_count <= out_count;
        end
    end

endmodule

// File: tb/tb_serial_match_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_match_ctrl
// Directed scenarios plus randomized traffic against a transaction-level
// model (sliding pattern window over the bit stream, cycle budget from
// accept to report). Inputs change at posedge+2, outputs compared at negedge.
// ----------------------------------------------------------------------------
module tb_serial_match_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          keep_hist = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic          busy;

    int tests = 0;
    int fails = 0;

    serial_match_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .keep_hist (keep_hist),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Matches of "1101" ending on a word bit; hist holds up to 3 previous
    // stream bits (hb[0] most recent).
    function automatic int exp_matches(input logic [DW-1:0] w, input int hl, input logic [2:0] hb);
        int s[DW+3];
        int n;
        int c;
        n = 0;
        c = 0;
        for (int k = hl - 1; k >= 0; k--) begin
            s[n] = int'(hb[k]);
            n++;
        end
        for (int k = DW - 1; k >= 0; k--) begin
            s[n] = int'(w[k]);
            n++;
        end
        for (int p = hl; p < n; p++) begin
            if (p >= 3 && s[p-3] == 1 && s[p-2] == 1 && s[p-1] == 0 && s[p] == 1) c++;
        end
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        return c;
    endfunction

    // ---------------- behavioural model ----------------
    bit       m_idle  = 1'b1;
    bit       m_valid = 1'b0;
    int       m_t     = 0;
    int       m_exp   = 0;
    int       m_hl    = 0;
    logic [2:0] m_hb  = 3'b000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_hl    = 0;
            m_hb    = 3'b000;
        end else if (m_idle) begin
            if (in_valid) begin
                if (!keep_hist) m_hl = 0;
                m_exp = exp_matches(in_data, m_hl, m_hb);
                for (int k = DW - 1; k >= 0; k--) begin
                    m_hb = {m_hb[1:0], in_data[k]};
                    if (m_hl < 3) m_hl++;
                end
                m_idle = 1'b0;
                m_t    = 0;
            end
        end else if (m_valid && out_ready) begin
            m_idle  = 1'b1;
            m_valid = 1'b0;
        end else begin
            m_t++;
            if (m_t == DW + 1) m_valid = 1'b1;
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_idle));
        chk("busy", int'(busy), int'(!m_idle));
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (m_valid) chk("out_count", int'(out_count), m_exp);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one word, check latency and literal count, hold REPORT, handshake
    task automatic run_word(input logic [DW-1:0] d, input logic k, input int hold, input int exp_cnt);
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        keep_hist = k;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", int'(n < 50), 1);
        step();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk("latency", n, DW + 1);
        if (exp_cnt >= 0) chk("count_lit", int'(out_count), exp_cnt);
        for (int j = 0; j < hold; j++) begin
            in_valid = j[0];
            in_data  = DW'($urandom);
            step();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_ready", int'(in_ready), 0);
            if (exp_cnt >= 0) chk("hold_count", int'(out_count), exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("after_hs", int'(out_valid), 0);
    endtask

    initial begin
        int n;
        int hs;
        int acc2;

        // model pins
        chk("model_a", exp_matches(8'b1101_0000, 0, 3'b000), 1);
        chk("model_b", exp_matches(8'b1101_1010, 0, 3'b000), 2);
        chk("model_c", exp_matches(8'hFF, 0, 3'b000), 0);
        chk("model_d", exp_matches(8'b1000_0000, 3, 3'b110), 1);
        chk("model_e", exp_matches(8'b1000_0000, 0, 3'b110), 0);

        step();
        step();
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(out_count), 0);
        rst = 1'b0;
        step();

        run_word(8'b1101_0000, 1'b0, 0, 1);
        run_word(8'b1101_1010, 1'b0, 0, 2);
        run_word(8'hFF,        1'b0, 0, 0);
        run_word(8'b0000_0110, 1'b0, 0, 0);
        run_word(8'b1000_0000, 1'b1, 0, 1);
        run_word(8'b0000_0110, 1'b0, 0, 0);
        run_word(8'b1000_0000, 1'b0, 0, 0);
        run_word(8'b1101_1010, 1'b0, 5, 2);

        // reset in the middle of a word (bit_cnt==4)
        in_valid  = 1'b1;
        in_data   = 8'b0110_1111;
        keep_hist = 1'b0;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) step();
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(out_count), 0);
        step();
        rst = 1'b0;
        for (int j = 0; j < 15; j++) begin
            step();
            chk("no_pulse", int'(out_valid), 0);
        end
        run_word(8'b1101_0000, 1'b1, 0, 1);

        // back-to-back: second accept one cycle after first handshake
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'b1101_0000;
        keep_hist = 1'b0;
        hs   = -1;
        acc2 = -1;
        n    = 0;
        while (acc2 < 0 && n < 60) begin
            if (out_valid && out_ready && hs < 0) hs = n;
            else if (in_ready && in_valid && hs >= 0) acc2 = n;
            step();
            n++;
        end
        chk("b2b_seen", int'(acc2 >= 0), 1);
        chk("b2b_gap", acc2 - hs, 1);
        in_valid  = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        out_ready = 1'b0;

        // randomized traffic with occasional reset
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = DW'($urandom);
            keep_hist = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_match_ctrl.md
SERIAL_MATCH_CTRL -- requirements
Module: serial_match_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per input word, serialized MSB-first.
REQ-002 SHALL have parameter CNT_WIDTH, default 4: width of the match count.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  word offered on in_data.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  word to scan.
REQ-007 SHALL have port keep_hist  input  1  1 = keep detector history across words; sampled at accept.
REQ-008 SHALL have port in_ready  output  1  controller can accept a word.
REQ-009 SHALL have port out_valid  output  1  out_count is valid.
REQ-010 SHALL have port out_count  output  CNT_WIDTH  number of "1101" matches in the word.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement controller FSM states IDLE, SHIFT, DRAIN and REPORT.
REQ-014 SHALL drive in_ready=1 only in IDLE; the accept edge is any posedge with in_valid&&in_ready.
REQ-015 At the accept edge SHALL capture in_data into a shift register, clear bit_cnt and out_count, and go IDLE->SHIFT.
REQ-016 At the accept edge SHALL synchronously clear the detector to its idle state when keep_hist=0, and leave it untouched when keep_hist=1.
REQ-017 In SHIFT SHALL present shift-register MSB as detector input each cycle, shift left, increment bit_cnt; SHIFT->DRAIN on the edge consuming bit DATA_WIDTH-1.
REQ-018 Detector SHALL be a Moore "1101" recognizer with overlap (states IDLE,S1,S2,S3,S4; o=1 only in S4; S4 on 1 -> S2, S2 on 1 -> S2).
REQ-019 SHALL increment out_count on each edge where detector o=1 and (state==SHIFT with bit_cnt!=0, or state==DRAIN).
REQ-020 out_count SHALL saturate at all-ones and never wrap.
REQ-021 DRAIN SHALL last exactly one cycle, then go to REPORT.
REQ-022 out_valid SHALL be 1 only in REPORT, asserting after accept edge + DATA_WIDTH+1 edges (edge 9 for default).
REQ-023 In REPORT, out_count SHALL hold stable until out_valid&&out_ready; on that edge go REPORT->IDLE.
REQ-024 SHALL ignore in_valid and in_data outside IDLE; no buffering of a second word.
REQ-025 Back-to-back operation: in_ready SHALL be 1 in the cycle after the output handshake edge.
REQ-026 Undefined FSM encodings SHALL go to IDLE.

Reset
REQ-027 On rst=1, SHALL go immediately to IDLE, detector to its idle state, out_count=0, out_valid=0, busy=0, and in_ready=1.
REQ-028 A rst asserted mid-SHIFT/DRAIN/REPORT SHALL abort the word with no out_valid pulse; the first post-reset word SHALL see no history.

Structure
REQ-029 Shared package SHALL hold the controller state enum and the detector state enum.
REQ-030 SHALL instantiate a sub-module seq_det_1101 (clk, rst, clr, i, o) as the detector; all else in serial_match_ctrl.

Verification
REQ-031 in_data=8'b1101_0000, keep_hist=0 -> out_count=1, out_valid rises after edge 9 from accept.
REQ-032 in_data=8'b1101_1010 -> out_count=2 (overlap); in_data=8'hFF -> out_count=0.
REQ-033 Word 8'b0000_0110 then 8'b1000_0000 with keep_hist=1 -> second count=1; same with keep_hist=0 -> 0.
REQ-034 out_ready low 5 cycles in REPORT -> out_valid, out_count stable, in_ready=0, in_valid pulses ignored.
REQ-035 rst pulse at bit_cnt=4 -> all outputs at reset values next cycle, no out_valid; next word 8'b1101_0000 -> count 1.
REQ-036 out_ready held high, in_valid held high, two words -> second accept edge one cycle after first output handshake.
